// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and access size codes.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_DONE  = 3'd4
  } arb_state_e;

  // Size codes as produced by decode.
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

endpackage

// File: rtl/dmem_dep_counter.sv
// Outstanding-store counter: saturating push/pop, cleared by flush.
module dmem_dep_counter #(
  parameter  int unsigned MAX_PEND = 4,
  localparam int unsigned CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] count_d;

  // Simultaneous push and pop cancel; out-of-range moves are dropped.
  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop && (count != CW'(MAX_PEND))) begin
      count_d = count + CW'(1);
    end else if (pop && !push && (count != '0)) begin
      count_d = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= count_d;
      full  <= (count_d == CW'(MAX_PEND));
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between operand loads and write-back stores.
// Optional statistics counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W   = 32,
  parameter  int unsigned DATA_W   = 64,
  parameter  int unsigned MAX_PEND = 4,
  localparam int unsigned CW       = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              dep_push,
  input  logic              dep_pop,
  output logic              dep_full,
  output logic [CW-1:0]     dep_count,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_size,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_size,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       rd_stall_cycles,
  output logic [15:0]       wr_count,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state, state_d;
  logic              drop, drop_d;
  logic              rd_ready_d, wr_ready_d, wr_done_d;
  logic              mem_valid_d, mem_we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        size_d;
  logic [DATA_W-1:0] wdata_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              mem_fire;

  assign mem_fire = mem_valid & mem_ready;

  dmem_dep_counter #(.MAX_PEND(MAX_PEND)) u_dep_counter (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (dep_push),
    .pop   (dep_pop),
    .count (dep_count),
    .full  (dep_full)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state;
    drop_d       = drop;
    rd_ready_d   = 1'b0;
    wr_ready_d   = 1'b0;
    wr_done_d    = 1'b0;
    mem_valid_d  = 1'b0;
    mem_we_d     = 1'b0;
    addr_d       = mem_addr;
    size_d       = mem_size;
    wdata_d      = mem_wdata;
    resp_valid_d = 1'b0;
    resp_data_d  = rd_resp_data;
    case (state)
      IDLE: begin
        if (wr_valid) begin
          wr_ready_d = 1'b1;
          mem_we_d   = 1'b1;
          addr_d     = wr_addr;
          size_d     = wr_size;
          wdata_d    = wr_data;
          state_d    = WR_ISSUE;
        end else if (rd_valid && (dep_count == '0) && !flush) begin
          rd_ready_d = 1'b1;
          addr_d     = rd_addr;
          size_d     = rd_size;
          wdata_d    = '0;
          drop_d     = 1'b0;
          state_d    = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (flush) drop_d = 1'b1;
        if (mem_fire) state_d = RD_WAIT;
        else          mem_valid_d = 1'b1;
      end
      RD_WAIT: begin
        if (mem_rdata_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!(drop || flush)) begin
            resp_valid_d = 1'b1;
            resp_data_d  = mem_rdata;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      WR_ISSUE: begin
        // Accepted stores always complete, even across a flush.
        if (mem_fire) begin
          state_d   = WR_DONE;
          wr_done_d = 1'b1;
        end else begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
        end
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      drop          <= 1'b0;
      rd_ready      <= 1'b0;
      wr_ready      <= 1'b0;
      wr_done       <= 1'b0;
      mem_valid     <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_size      <= '0;
      mem_wdata     <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else begin
      state         <= state_d;
      drop          <= drop_d;
      rd_ready      <= rd_ready_d;
      wr_ready      <= wr_ready_d;
      wr_done       <= wr_done_d;
      mem_valid     <= mem_valid_d;
      mem_we        <= mem_we_d;
      mem_addr      <= addr_d;
      mem_size      <= size_d;
      mem_wdata     <= wdata_d;
      rd_resp_valid <= resp_valid_d;
      rd_resp_data  <= resp_data_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating activity counters; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_stall_cycles <= '0;
      wr_count        <= '0;
    end else begin
      if (rd_valid && !rd_ready && (rd_stall_cycles != 16'hFFFF))
        rd_stall_cycles <= rd_stall_cycles + 16'd1;
      if (wr_ready && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed loads, stores, dependency and flush/reset cases.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CW     = 3;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush, dep_push, dep_pop, dep_full;
  logic [CW-1:0]     dep_count;
  logic              rd_valid, rd_ready, rd_resp_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_size;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_valid, wr_ready, wr_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_size;
  logic [DATA_W-1:0] wr_data;
  logic              mem_valid, mem_ready, mem_we, mem_rdata_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]       rd_stall_cycles, wr_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  mreq_t             exp_mem[$];
  logic [DATA_W-1:0] exp_rd[$];
  logic [ADDR_W-1:0] exp_wr[$];

  logic              hold = 1'b0;
  logic              rd_pend;
  logic [DATA_W-1:0] rdata_val = '0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dep_push(dep_push), .dep_pop(dep_pop), .dep_full(dep_full), .dep_count(dep_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_data(wr_data), .wr_done(wr_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata_valid(mem_rdata_valid),
`ifdef DMEM_ARB_STATS_EN
    .rd_stall_cycles(rd_stall_cycles), .wr_count(wr_count),
`endif
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory model: read data one cycle after the accepted request unless held.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rdata_valid <= 1'b0;
      mem_rdata       <= '0;
      rd_pend         <= 1'b0;
    end else begin
      mem_rdata_valid <= 1'b0;
      if (mem_valid && mem_ready && !mem_we) begin
        if (hold) rd_pend <= 1'b1;
        else begin
          mem_rdata_valid <= 1'b1;
          mem_rdata       <= rdata_val;
        end
      end else if (rd_pend && !hold) begin
        rd_pend         <= 1'b0;
        mem_rdata_valid <= 1'b1;
        mem_rdata       <= rdata_val;
      end
    end
  end

  // Monitor: pops expected transactions whenever the DUT presents one.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_valid && mem_ready) begin
        if (exp_mem.size() == 0) check("unexpected mem_req", 128'(1), 128'(0));
        else check("mem_req", 128'(mreq_t'{mem_we, mem_addr, mem_size, mem_wdata}),
                   128'(exp_mem.pop_front()));
      end
      if (rd_resp_valid) begin
        if (exp_rd.size() == 0) check("unexpected rd_resp", 128'(1), 128'(0));
        else check("rd_resp_data", 128'(rd_resp_data), 128'(exp_rd.pop_front()));
      end
      if (wr_done) begin
        if (exp_wr.size() == 0) check("unexpected wr_done", 128'(1), 128'(0));
        else check("wr_done addr", 128'(mem_addr), 128'(exp_wr.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [2:0] s);
    bit ok;
    exp_mem.push_back(mreq_t'{1'b1, a, s, d});
    exp_wr.push_back(a);
    cyc(); wr_valid = 1'b1; wr_addr = a; wr_size = s; wr_data = d;
    wait_wr(ok);
    check("wr_ready granted", 128'(ok), 128'(1));
    cyc(); wr_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [63:0] rdat, input bit keep_resp);
    bit ok;
    exp_mem.push_back(mreq_t'{1'b0, a, SZ_DWORD, 64'd0});
    if (keep_resp) exp_rd.push_back(rdat);
    rdata_val = rdat;
    cyc(); rd_valid = 1'b1; rd_addr = a; rd_size = SZ_DWORD;
    wait_rd(ok);
    check("rd_ready granted", 128'(ok), 128'(1));
    cyc(); rd_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " mem_valid"}, 128'(mem_valid), 128'(0));
    check({tag, " mem_we"}, 128'(mem_we), 128'(0));
    check({tag, " mem_addr"}, 128'(mem_addr), 128'(0));
    check({tag, " mem_wdata"}, 128'(mem_wdata), 128'(0));
    check({tag, " rd_ready"}, 128'(rd_ready), 128'(0));
    check({tag, " wr_ready"}, 128'(wr_ready), 128'(0));
    check({tag, " wr_done"}, 128'(wr_done), 128'(0));
    check({tag, " rd_resp_valid"}, 128'(rd_resp_valid), 128'(0));
    check({tag, " dep_count"}, 128'(dep_count), 128'(0));
    check({tag, " dep_full"}, 128'(dep_full), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, got_w, got_r, blocked_ok, resp_seen, rdv_seen;
    reset = 1'b0; flush = 1'b0; dep_push = 1'b0; dep_pop = 1'b0;
    rd_valid = 1'b0; rd_addr = '0; rd_size = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // Store with latency checks.
    do_store(32'h100, 64'hDEADBEEF, SZ_DWORD);
    @(negedge clk);
    check("store mem_valid N+1", 128'(mem_valid), 128'(1));
    check("store mem_we N+1", 128'(mem_we), 128'(1));
    check("store wr_done not yet", 128'(wr_done), 128'(0));
    @(negedge clk);
    check("store wr_done N+2", 128'(wr_done), 128'(1));
    check("store mem_valid dropped", 128'(mem_valid), 128'(0));

    // Load blocked by pending stores.
    cyc(); dep_push = 1'b1;
    cyc(); cyc(); dep_push = 1'b0;
    @(negedge clk);
    check("dep_count two", 128'(dep_count), 128'(2));
    exp_mem.push_back(mreq_t'{1'b0, 32'h200, SZ_WORD, 64'd0});
    exp_rd.push_back(64'h1234);
    rdata_val = 64'h1234;
    cyc(); rd_valid = 1'b1; rd_addr = 32'h200; rd_size = SZ_WORD;
    blocked_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_ready) blocked_ok = 1'b0;
    end
    check("load held while stores pending", 128'(blocked_ok), 128'(1));
    cyc(); dep_pop = 1'b1;
    cyc(); cyc(); dep_pop = 1'b0;
    @(negedge clk);
    check("dep_count after pops", 128'(dep_count), 128'(0));
    wait_rd(ok);
    check("load granted after pops", 128'(ok), 128'(1));
    cyc(); rd_valid = 1'b0;
    @(negedge clk);
    check("load mem_valid N+1", 128'(mem_valid), 128'(1));
    @(negedge clk);
    check("load resp not before N+3", 128'(rd_resp_valid), 128'(0));
    @(negedge clk);
    check("load resp at N+3", 128'(rd_resp_valid), 128'(1));

    // Simultaneous read and write: write first.
    exp_mem.push_back(mreq_t'{1'b1, 32'h300, SZ_HALF, 64'hA5A5});
    exp_wr.push_back(32'h300);
    exp_mem.push_back(mreq_t'{1'b0, 32'h400, SZ_DWORD, 64'd0});
    exp_rd.push_back(64'h55AA_0011_2233_4455);
    rdata_val = 64'h55AA_0011_2233_4455;
    cyc();
    wr_valid = 1'b1; wr_addr = 32'h300; wr_size = SZ_HALF; wr_data = 64'hA5A5;
    rd_valid = 1'b1; rd_addr = 32'h400; rd_size = SZ_DWORD;
    got_w = 1'b0; got_r = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr_ready && !got_w) begin
        got_w = 1'b1;
        check("arb no rd_ready with write grant", 128'(rd_ready), 128'(0));
      end
      if (rd_ready) begin
        got_r = 1'b1;
        check("arb read after write", 128'(got_w), 128'(1));
      end
      @(posedge clk); #1;
      if (got_w) wr_valid = 1'b0;
      if (got_r) begin rd_valid = 1'b0; break; end
    end
    check("arb both granted", 128'({got_w, got_r}), 128'(2'b11));
    rd_valid = 1'b0; wr_valid = 1'b0;
    repeat (4) cyc();

    // Counter saturation.
    dep_push = 1'b1;
    repeat (5) cyc();
    dep_push = 1'b0;
    @(negedge clk);
    check("sat dep_count", 128'(dep_count), 128'(4));
    check("sat dep_full", 128'(dep_full), 128'(1));
    cyc(); dep_push = 1'b1; dep_pop = 1'b1;
    cyc(); dep_push = 1'b0; dep_pop = 1'b0;
    @(negedge clk);
    check("push+pop unchanged", 128'(dep_count), 128'(4));
    cyc(); dep_pop = 1'b1;
    repeat (4) cyc();
    dep_pop = 1'b0;
    @(negedge clk);
    check("drained dep_count", 128'(dep_count), 128'(0));
    check("drained dep_full", 128'(dep_full), 128'(0));
    cyc(); dep_pop = 1'b1;
    cyc(); dep_pop = 1'b0;
    @(negedge clk);
    check("pop at zero", 128'(dep_count), 128'(0));

    // Flush during RD_WAIT drops the response.
    hold = 1'b1;
    do_load(32'h500, 64'hBAD, 1'b0);
    dep_push = 1'b1;
    repeat (3) cyc();
    dep_push = 1'b0;
    @(negedge clk);
    check("flush pre dep_count", 128'(dep_count), 128'(3));
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0;
    @(negedge clk);
    check("flush dep_count cleared", 128'(dep_count), 128'(0));
    cyc(); hold = 1'b0;
    resp_seen = 1'b0; rdv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_resp_valid) resp_seen = 1'b1;
      if (mem_rdata_valid) rdv_seen = 1'b1;
    end
    check("flush rdata returned", 128'(rdv_seen), 128'(1));
    check("flush response dropped", 128'(resp_seen), 128'(0));
    do_load(32'h600, 64'h77, 1'b1);
    repeat (4) cyc();

    // Asynchronous reset during WR_ISSUE with memory stalled.
    dep_push = 1'b1;
    repeat (2) cyc();
    dep_push = 1'b0;
    mem_ready = 1'b0;
    cyc(); wr_valid = 1'b1; wr_addr = 32'h700; wr_size = SZ_DWORD; wr_data = 64'h99;
    wait_wr(ok);
    check("rst store granted", 128'(ok), 128'(1));
    cyc(); wr_valid = 1'b0;
    @(negedge clk);
    check("rst mem_valid before reset", 128'(mem_valid), 128'(1));
    #2 reset = 1'b0;
    #1 check("rst mem_valid async clear", 128'(mem_valid), 128'(0));
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("post-reset");
    do_load(32'h800, 64'hABCD, 1'b1);
    repeat (6) cyc();

    check("exp_mem drained", 128'(exp_mem.size()), 128'(0));
    check("exp_rd drained", 128'(exp_rd.size()), 128'(0));
    check("exp_wr drained", 128'(exp_wr.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the memory read stage (operand loads) and the write back stage (stores).
- Tracks in-flight memory-destination instructions: pushed when memory read dispatches one, popped on wb_valid & wb_ready & wb_to_memory.
- Holds loads off while any older store is pending, which prevents memory RAW hazards.
- Sits between memory_read_top/writeback and the data-memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width (matches 64-bit operands).
- MAX_PEND, 4, maximum outstanding memory-write dependencies; counter width is clog2(MAX_PEND+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  pipeline flush.
- dep_push  in  1  memory read dispatched an instruction that writes memory.
- dep_pop  in  1  wb_valid & wb_ready & wb_to_memory.
- dep_full  out  1  dep_count == MAX_PEND.
- dep_count  out  CW  outstanding store count.
- rd_valid  in  1  load request.
- rd_ready  out  1  load accepted (one-cycle pulse).
- rd_addr  in  ADDR_W  load address.
- rd_size  in  3  size code (decode encoding).
- rd_resp_valid  out  1  load data valid (one-cycle pulse).
- rd_resp_data  out  DATA_W  load data.
- wr_valid  in  1  store request.
- wr_ready  out  1  store accepted (one-cycle pulse).
- wr_addr  in  ADDR_W  store address.
- wr_size  in  3  size code.
- wr_data  in  DATA_W  store data.
- wr_done  out  1  store completed at memory (one-cycle pulse).
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  request address.
- mem_size  out  3  request size.
- mem_wdata  out  DATA_W  write data.
- mem_rdata_valid  in  1  read data returned.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0, state IDLE, dep_count 0, request registers 0.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_DONE.
- IDLE, write grant: wr_valid=1. Pulse wr_ready, latch addr/size/data, go to WR_ISSUE. A write wins over a simultaneous read.
- IDLE, read grant: rd_valid=1 && dep_count==0 && !flush && no write grant. Pulse rd_ready, latch request, go to RD_ISSUE.
- RD_ISSUE / WR_ISSUE:
  - mem_valid=1; mem_we=0 or 1 respectively.
  - mem_addr/size/wdata come from registers and stay stable until mem_ready.
  - On mem_valid & mem_ready, go to RD_WAIT or WR_DONE respectively.
- RD_WAIT:
  - On mem_rdata_valid, register the data; rd_resp_valid pulses the next cycle; return to IDLE.
  - mem_rdata_valid=0 means wait indefinitely.
- WR_DONE: wr_done=1 for one cycle, then IDLE.
- Latencies with mem_ready and rdata returned immediately:
  - Load: rd_ready at cycle N, mem_valid at N+1, rd_resp_valid at N+3 when rdata returns at N+2.
  - Store: wr_ready at N, mem_valid at N+1, wr_done at N+2.
- dep_count:
  - push only: +1.
  - pop only: -1.
  - both together: unchanged.
  - push at MAX_PEND: ignored (dep_full already high; upstream must hold).
  - pop at 0: ignored.
- flush:
  - dep_count cleared to 0; a simultaneous push is ignored, a simultaneous pop is irrelevant.
  - In RD_ISSUE: request still completes, but the response is dropped (a drop flag is set; rd_resp_valid stays 0).
  - In RD_WAIT: response dropped.
  - Writes already accepted always complete and wr_done still pulses; stores are older than the flush point.
  - No new read grant in a flush cycle.
- Reset asserted mid-operation: immediate return to IDLE, outstanding memory transaction abandoned, outputs 0.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output rd_stall_cycles [15:0]: counts cycles with rd_valid=1 and no rd_ready.
  - Adds output wr_count [15:0]: counts accepted stores.
  - Both saturate at 16'hFFFF, clear on reset, are unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package (dmem_arb_pkg):
  - FSM state encoding localparams: IDLE=0, RD_ISSUE=1, RD_WAIT=2, WR_ISSUE=3, WR_DONE=4.
  - Size-code constants shared with decode.
- One natural sub-module: dmem_dep_counter, the saturating push/pop/flush counter producing dep_count and dep_full.

Test Plan:
- Store: wr_valid with addr 0x100, data 0xDEADBEEF, size 3, mem_ready=1 -> wr_ready pulse, next cycle mem_valid=1 with we=1, addr 0x100, wdata 0xDEADBEEF; wr_done one cycle later.
- Load blocked: dep_push twice (dep_count=2), rd_valid addr 0x200 -> no rd_ready. Two dep_pop pulses -> count 0, then rd_ready; mem_rdata 0x1234 -> rd_resp_data 0x1234.
- Arbitration: rd_valid & wr_valid in same IDLE cycle, count 0 -> write served first, read granted on the next IDLE cycle.
- Saturation: 5 pushes with MAX_PEND=4 -> dep_count=4, dep_full=1. Simultaneous push+pop -> stays 4. 4 pops then an extra pop -> stays 0.
- Flush: flush during RD_WAIT with dep_count=3 -> dep_count=0, mem_rdata_valid returns, rd_resp_valid stays 0, FSM back to IDLE.
- Reset: reset low during WR_ISSUE with mem_ready=0 -> mem_valid=0 immediately (asynchronous); after release, all outputs 0 and state IDLE.
